sif_xa_master: RTL

- Initiator for the SIF external-access (xa) port; drives `xa_wr_s`, `xa_rd_s`, `xa_addr` and `xa_data_wr`, and samples `xa_data_rd`.
- Accepts queued read/write commands on a valid/ready interface and serialises them into single-cycle xa strobes with fixed read latency and a minimum inter-strobe gap.
- Returns read data on a valid/ready response interface.
- Replaces hand-driven xa stimulus in system integration.

---
 rtl/sif_xa_master.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/sif_xa_master.sv
// sif_xa_master: queues read/write commands and serialises them into single-cycle SIF xa strobes.
// Optional: define SIF_XA_WR_VERIFY_EN to read back every write and flag mismatches on wr_err.
module sif_xa_master #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 2,
    parameter int GAP        = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_wr,
    input  logic [ADDR_W-1:0]           cmd_addr,
    input  logic [DATA_W-1:0]           cmd_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ADDR_W-1:0]           rsp_addr,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        xa_wr_s,
    output logic                        xa_rd_s,
    output logic [ADDR_W-1:0]           xa_addr,
    output logic [DATA_W-1:0]           xa_data_wr,
    input  logic [DATA_W-1:0]           xa_data_rd,
    output logic                        busy,
`ifdef SIF_XA_WR_VERIFY_EN
    output logic                        wr_err,
    output logic [ADDR_W-1:0]           wr_err_addr,
`endif
    output logic [$clog2(FIFO_DEPTH):0] cmd_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (RD_LAT > GAP) ? RD_LAT : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RD_WAIT, S_GAP} state_t;

    cmd_t              fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q;
    cmd_t              head;
    logic              push, pop, dispatch, vfy_go, rd_ok, last_rd, last_gap, iss_vfy;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    cmd_t              iss_q;
    logic              rsp_valid_q;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              xa_wr_s_q, xa_rd_s_q;
    logic [ADDR_W-1:0] xa_addr_q;
    logic [DATA_W-1:0] xa_data_wr_q;
`ifdef SIF_XA_WR_VERIFY_EN
    logic              vfy_pend_q, iss_vfy_q, wr_err_q;
    logic [ADDR_W-1:0] wr_err_addr_q;
`endif

    assign head      = fifo_mem[rd_ptr_q];
    assign cmd_ready = !rst && (count_q != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign last_rd   = (cnt_q == CNT_W'(RD_LAT));
    assign last_gap  = (cnt_q == CNT_W'(GAP));
    // A read may only leave the FIFO once the response slot is (or is becoming) free.
    assign rd_ok     = (!rsp_valid_q || rsp_ready) && (state_q != S_RD_WAIT);

`ifdef SIF_XA_WR_VERIFY_EN
    assign iss_vfy = iss_vfy_q;
    assign vfy_go  = dispatch && vfy_pend_q;
`else
    assign iss_vfy = 1'b0;
    assign vfy_go  = 1'b0;
`endif

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        dispatch = 1'b0;
        unique case (state_q)
            S_IDLE:    dispatch = 1'b1;
            S_ISSUE:   dispatch = (GAP == 0) && iss_q.wr;
            S_RD_WAIT: dispatch = (GAP == 0) && last_rd;
            S_GAP:     dispatch = last_gap;
            default:   dispatch = 1'b0;
        endcase
    end

    assign pop = dispatch && !vfy_go && (count_q != '0) && (head.wr || rd_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + (PTR_W + 1)'(1);
            else if (pop && !push) count_q <= count_q - (PTR_W + 1)'(1);
        end
    end

    // NOTE: FIFO storage is deliberately not reset; an entry is never read before it is written.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= '{wr: cmd_wr, addr: cmd_addr, data: cmd_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            iss_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_addr_q   <= '0;
            rsp_data_q   <= '0;
            xa_wr_s_q    <= 1'b0;
            xa_rd_s_q    <= 1'b0;
            xa_addr_q    <= '0;
            xa_data_wr_q <= '0;
`ifdef SIF_XA_WR_VERIFY_EN
            vfy_pend_q    <= 1'b0;
            iss_vfy_q     <= 1'b0;
            wr_err_q      <= 1'b0;
            wr_err_addr_q <= '0;
`endif
        end else begin
            xa_wr_s_q <= 1'b0;
            xa_rd_s_q <= 1'b0;
            if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;

            unique case (state_q)
                S_IDLE: ;
                S_ISSUE: begin
                    cnt_q <= CNT_W'(1);
                    if (!iss_q.wr)    state_q <= S_RD_WAIT;
                    else if (GAP == 0) state_q <= S_IDLE;
                    else               state_q <= S_GAP;
                end
                S_RD_WAIT: begin
                    if (last_rd) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= (GAP == 0) ? S_IDLE : S_GAP;
                        if (iss_vfy) begin
`ifdef SIF_XA_WR_VERIFY_EN
                            // First mismatching address is kept until reset.
                            if (xa_data_rd != iss_q.data) begin
                                wr_err_q <= 1'b1;
                                if (!wr_err_q) wr_err_addr_q <= iss_q.addr;
                            end
`endif
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_addr_q  <= iss_q.addr;
                            rsp_data_q  <= xa_data_rd;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (last_gap) state_q <= S_IDLE;
                    else          cnt_q   <= cnt_q + CNT_W'(1);
                end
                default: state_q <= S_IDLE;
            endcase

`ifdef SIF_XA_WR_VERIFY_EN
            if (vfy_go) begin
                state_q    <= S_ISSUE;
                xa_rd_s_q  <= 1'b1;
                xa_addr_q  <= iss_q.addr;
                iss_q.wr   <= 1'b0;
                iss_vfy_q  <= 1'b1;
                vfy_pend_q <= 1'b0;
            end else
`endif
            if (pop) begin
                state_q   <= S_ISSUE;
                iss_q     <= head;
                xa_addr_q <= head.addr;
                if (head.wr) begin
                    xa_wr_s_q    <= 1'b1;
                    xa_data_wr_q <= head.data;
                end else begin
                    xa_rd_s_q <= 1'b1;
                end
`ifdef SIF_XA_WR_VERIFY_EN
                iss_vfy_q  <= 1'b0;
                vfy_pend_q <= head.wr;
`endif
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_addr   = rsp_addr_q;
    assign rsp_data   = rsp_data_q;
    assign xa_wr_s    = xa_wr_s_q;
    assign xa_rd_s    = xa_rd_s_q;
    assign xa_addr    = xa_addr_q;
    assign xa_data_wr = xa_data_wr_q;
    assign busy       = (count_q != '0) || (state_q != S_IDLE);
    assign cmd_count  = count_q;
`ifdef SIF_XA_WR_VERIFY_EN
    assign wr_err      = wr_err_q;
    assign wr_err_addr = wr_err_addr_q;
`endif

endmodule
